// File: rtl/mux_2in_1out.sv
// Registered 2-to-1 operand multiplexer: Q loads (sel ? B : A) on an enabled rising edge.
// Define MUX_2IN_1OUT_PARITY_EN to add Q_par, the registered even parity of the loaded value.
module mux_2in_1out #(
    parameter int unsigned       LENGTH      = 32,
    parameter logic [LENGTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [LENGTH-1:0] A,
    input  logic [LENGTH-1:0] B,
    input  logic              sel,
`ifdef MUX_2IN_1OUT_PARITY_EN
    output logic              Q_par,
`endif
    output logic [LENGTH-1:0] Q
);

    logic [LENGTH-1:0] w_sel_data;
    logic [LENGTH-1:0] r_q;

    assign w_sel_data = sel ? B : A;

    // Reset wins over any pending load, so a captured value never survives rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (enable) begin
            r_q <= w_sel_data;
        end
    end

    assign Q = r_q;

`ifdef MUX_2IN_1OUT_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= ^RESET_VALUE;
        end else if (enable) begin
            r_par <= ^w_sel_data;
        end
    end

    assign Q_par = r_par;
`endif

endmodule

// File: tb/tb_mux_2in_1out.sv
// Bench for mux_2in_1out: vector table plus reset/async-reset sequences and a random
// section, all checked through an expected-value queue. An 8-bit instance checks RESET_VALUE.
module tb_mux_2in_1out;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sel;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] q32;
    logic        sel8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  q8;
`ifdef MUX_2IN_1OUT_PARITY_EN
    logic        q32_par;
    logic        q8_par;
`endif

    mux_2in_1out #(.LENGTH(32), .RESET_VALUE(32'h0000_0000)) dut32 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .A      (a32),
        .B      (b32),
        .sel    (sel),
`ifdef MUX_2IN_1OUT_PARITY_EN
        .Q_par  (q32_par),
`endif
        .Q      (q32)
    );

    mux_2in_1out #(.LENGTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .A      (a8),
        .B      (b8),
        .sel    (sel8),
`ifdef MUX_2IN_1OUT_PARITY_EN
        .Q_par  (q8_par),
`endif
        .Q      (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_pop(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %h, expected queue empty", name, q32);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(q32), 64'(e));
`ifdef MUX_2IN_1OUT_PARITY_EN
            check({name, "_par"}, 64'(q32_par), 64'(^e));
`endif
        end
    endtask

    logic [31:0] model_q;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002};
        vecs[3]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0002};
        vecs[4]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0002};
        vecs[5]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0002};
        vecs[6]  = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0002, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b1, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
        vecs[8]  = '{1'b1, 1'b0, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        vecs[12] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};

        // Reset held with a load-worthy input pattern; Q must be the reset value before any edge.
        rst = 1'b1; enable = 1'b1; sel = 1'b1; a32 = 32'h1; b32 = 32'h2;
        sel8 = 1'b1; a8 = 8'h00; b8 = 8'h07;
        #1;
        check("rst_pre_edge", 64'(q32), 64'h0);
        check("rst8_pre_edge", 64'(q8), 64'hA5);
`ifdef MUX_2IN_1OUT_PARITY_EN
        check("rst8_par", 64'(q8_par), 64'h0);
        check("rst32_par", 64'(q32_par), 64'h0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", 64'(q32), 64'h0);
        check("rst8_hold", 64'(q8), 64'hA5);

        @(negedge clk);
        rst = 1'b0;
        model_q = 32'h0;
        for (int i = 0; i < 13; i++) begin
            enable = vecs[i].en; sel = vecs[i].sel; a32 = vecs[i].a; b32 = vecs[i].b;
            exp_q.push_back(vecs[i].q);
            #1;
            check($sformatf("vec%0d_pre_edge", i), 64'(q32), 64'(model_q));
            @(posedge clk);
            #1;
            check_pop($sformatf("vec%0d", i));
            model_q = vecs[i].q;
            if (i == 0) begin
                check("vec0_q8", 64'(q8), 64'h07);
`ifdef MUX_2IN_1OUT_PARITY_EN
                check("vec0_q8_par", 64'(q8_par), 64'h1);
`endif
            end
            @(negedge clk);
        end

        // Asynchronous reset pulse between edges, then reload on the first enabled edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_now", 64'(q32), 64'h0);
        check("async_rst8_now", 64'(q8), 64'hA5);
        @(posedge clk);
        #1;
        check("async_rst_hold", 64'(q32), 64'h0);
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; sel = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h2;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        check("after_rst_pre_edge", 64'(q32), 64'h0);
        @(posedge clk);
        #1;
        check_pop("after_rst_reload");
        check("after_rst8_reload", 64'(q8), 64'h07);
        model_q = 32'hDEAD_BEEF;

        // Random traffic against a behavioural reference.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            enable = 1'($urandom_range(0, 3) != 0);
            sel    = 1'($urandom_range(0, 1));
            a32    = $urandom;
            b32    = (i % 5 == 0) ? a32 : $urandom;
            if (enable) model_q = sel ? b32 : a32;
            exp_q.push_back(model_q);
            @(posedge clk);
            #1;
            check_pop($sformatf("rand%0d", i));
        end

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
